mem_port_arbiter: RTL and testbench

//  Shares one syn/ack/last memory port between instruction fetch (port 0) and load/store unit (port 1).

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin burst arbiter for a shared syn/ack/last memory port
module mem_port_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 32,
    parameter int TO_WIDTH = 8
) (
    input  logic                a_clk,
    input  logic                a_rst,

    input  logic                r0_syn,
    input  logic [AWIDTH-1:0]   r0_addr,
    output logic                r0_ack,
    output logic                r0_last,
    output logic [DWIDTH-1:0]   r0_rdata,
    output logic                r0_err,

    input  logic                r1_syn,
    input  logic [AWIDTH-1:0]   r1_addr,
    input  logic                r1_we,
    input  logic [DWIDTH-1:0]   r1_wdata,
    input  logic [DWIDTH/8-1:0] r1_wsel,
    output logic                r1_ack,
    output logic                r1_last,
    output logic [DWIDTH-1:0]   r1_rdata,
    output logic                r1_err,

    output logic                m_syn,
    output logic [AWIDTH-1:0]   m_addr,
    output logic                m_we,
    output logic [DWIDTH-1:0]   m_wdata,
    output logic [DWIDTH/8-1:0] m_wsel,
    input  logic                m_ack,
    input  logic                m_last,
    input  logic [DWIDTH-1:0]   m_rdata,

    output logic                a_o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Trip one count early so the timeout fires on the (2**TO_WIDTH-1)-th silent grant cycle.
    localparam logic [TO_WIDTH-1:0] WD_TRIP = TO_WIDTH'((1 << TO_WIDTH) - 2);

    state_t              state;
    state_t              state_nx;
    logic                last_gnt;
    logic [TO_WIDTH-1:0] wdog;

    logic                gnt_syn;
    logic                timeout;
    logic                burst_end;

    always_comb begin
        gnt_syn = 1'b0;
        case (state)
            GNT0:    gnt_syn = r0_syn;
            GNT1:    gnt_syn = r1_syn;
            default: gnt_syn = 1'b0;
        endcase
    end

    assign timeout   = (state != IDLE) && !m_ack && (wdog == WD_TRIP);
    assign burst_end = (state != IDLE) &&
                       ((m_ack && m_last) || (!gnt_syn && !m_ack) || timeout);

    // State register, round-robin history, watchdog and error pulses.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            wdog     <= '0;
            r0_err   <= 1'b0;
            r1_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == GNT0) begin
                last_gnt <= 1'b0;
            end else if (state == IDLE && state_nx == GNT1) begin
                last_gnt <= 1'b1;
            end
            if (state == IDLE || burst_end || m_ack) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end
            r0_err <= timeout && (state == GNT0);
            r1_err <= timeout && (state == GNT1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (r0_syn && r1_syn) begin
                    state_nx = last_gnt ? GNT0 : GNT1;
                end else if (r0_syn) begin
                    state_nx = GNT0;
                end else if (r1_syn) begin
                    state_nx = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (burst_end) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Port muxing is purely combinational from the grant state; IDLE drives everything quiet.
    always_comb begin
        m_syn    = 1'b0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_wdata  = '0;
        m_wsel   = '0;
        r0_ack   = 1'b0;
        r0_last  = 1'b0;
        r0_rdata = '0;
        r1_ack   = 1'b0;
        r1_last  = 1'b0;
        r1_rdata = '0;
        case (state)
            GNT0: begin
                m_syn    = r0_syn;
                m_addr   = r0_addr;
                r0_ack   = m_ack;
                r0_last  = m_last;
                r0_rdata = m_rdata;
            end
            GNT1: begin
                m_syn    = r1_syn;
                m_addr   = r1_addr;
                m_we     = r1_we;
                m_wdata  = r1_wdata;
                m_wsel   = r1_wsel;
                r1_ack   = m_ack;
                r1_last  = m_last;
                r1_rdata = m_rdata;
            end
            default: begin
            end
        endcase
    end

    assign a_o_busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 3;
    localparam int SILENT_LIMIT = (1 << TW) - 1;

    logic          a_clk = 1'b0;
    logic          a_rst;
    logic          r0_syn, r1_syn, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r1_wdata, m_rdata;
    logic [3:0]    r1_wsel;
    logic          m_ack, m_last;
    logic          r0_ack, r0_last, r0_err, r1_ack, r1_last, r1_err;
    logic [DW-1:0] r0_rdata, r1_rdata, m_wdata;
    logic          m_syn, m_we, a_o_busy;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_wsel;

    mem_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .TO_WIDTH(TW)) dut (
        .a_clk(a_clk), .a_rst(a_rst),
        .r0_syn(r0_syn), .r0_addr(r0_addr), .r0_ack(r0_ack), .r0_last(r0_last),
        .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_syn(r1_syn), .r1_addr(r1_addr), .r1_we(r1_we), .r1_wdata(r1_wdata),
        .r1_wsel(r1_wsel), .r1_ack(r1_ack), .r1_last(r1_last), .r1_rdata(r1_rdata),
        .r1_err(r1_err),
        .m_syn(m_syn), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_wsel(m_wsel),
        .m_ack(m_ack), .m_last(m_last), .m_rdata(m_rdata),
        .a_o_busy(a_o_busy)
    );

    always #5 a_clk = ~a_clk;

    int n_vec = 0;
    int n_chk = 0;
    int n_bad = 0;
    int ack0_seen = 0;
    int err0_seen = 0;
    int err1_seen = 0;

    // Reference: who owns the memory (-1 none), who was served last, silent grant cycles, pending errors.
    int owner;
    int served_last;
    int silent;
    bit err_due [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic ref_reset();
        owner       = -1;
        served_last = 1;
        silent      = 0;
        err_due[0]  = 1'b0;
        err_due[1]  = 1'b0;
    endtask

    task automatic ref_clock();
        bit want [2];
        bit quiet_limit;
        bit done;
        want[0] = r0_syn;
        want[1] = r1_syn;
        if (a_rst) begin
            ref_reset();
        end else if (owner < 0) begin
            err_due[0] = 1'b0;
            err_due[1] = 1'b0;
            silent     = 0;
            if (want[0] && want[1]) owner = 1 - served_last;
            else if (want[0])       owner = 0;
            else if (want[1])       owner = 1;
            if (owner >= 0) served_last = owner;
        end else begin
            quiet_limit = !m_ack && (silent + 1 == SILENT_LIMIT);
            done = (m_ack && m_last) || (!want[owner] && !m_ack) || quiet_limit;
            err_due[0] = quiet_limit && owner == 0;
            err_due[1] = quiet_limit && owner == 1;
            silent = m_ack ? 0 : silent + 1;
            if (done) begin
                owner  = -1;
                silent = 0;
            end
        end
    endtask

    // One cycle: check outputs mid-cycle against the reference, then advance both on the edge.
    task automatic tick();
        @(negedge a_clk);
        n_vec++;
        check("busy",  a_o_busy, owner >= 0);
        check("m_syn", m_syn, owner == 0 ? r0_syn : owner == 1 ? r1_syn : 1'b0);
        check("m_addr", m_addr, owner == 0 ? r0_addr : owner == 1 ? r1_addr : '0);
        check("m_we",  m_we, owner == 1 && r1_we);
        check("m_wdata", m_wdata, owner == 1 ? r1_wdata : '0);
        check("m_wsel", m_wsel, owner == 1 ? r1_wsel : 4'h0);
        check("r0_ack", r0_ack, owner == 0 && m_ack);
        check("r1_ack", r1_ack, owner == 1 && m_ack);
        check("r0_last", r0_last, owner == 0 && m_last);
        check("r1_last", r1_last, owner == 1 && m_last);
        check("r0_rdata", r0_rdata, owner == 0 ? m_rdata : '0);
        check("r1_rdata", r1_rdata, owner == 1 ? m_rdata : '0);
        check("r0_err", r0_err, err_due[0]);
        check("r1_err", r1_err, err_due[1]);
        if (r0_ack === 1'b1) ack0_seen++;
        if (r0_err === 1'b1) err0_seen++;
        if (r1_err === 1'b1) err1_seen++;
        @(posedge a_clk);
        ref_clock();
        #1;
    endtask

    initial begin
        a_rst = 1'b1;
        r0_syn = 0; r1_syn = 0; r1_we = 0;
        r0_addr = '0; r1_addr = '0; r1_wdata = '0; r1_wsel = '0;
        m_ack = 0; m_last = 0; m_rdata = '0;
        @(posedge a_clk);
        ref_reset();
        #1;
        tick();

        // Three-beat fetch burst.
        a_rst = 1'b0;
        r0_syn = 1; r0_addr = 32'h100;
        ack0_seen = 0;
        tick();
        m_ack = 1; m_rdata = 32'h11; tick();
        m_rdata = 32'h22; tick();
        m_last = 1; m_rdata = 32'h33; tick();
        r0_syn = 0; m_ack = 0; m_last = 0;
        tick();
        check("s1_beats", ack0_seen, 3);

        // Simultaneous requests after reset: fetch first, LSU after one idle cycle.
        a_rst = 1; tick();
        a_rst = 0; r0_syn = 1; r1_syn = 1;
        r1_addr = 32'h40; r1_we = 1; r1_wdata = 32'hDEADBEEF; r1_wsel = 4'b0011;
        tick();
        m_ack = 1; m_last = 1; tick();
        m_ack = 0; m_last = 0; tick();
        m_ack = 1;
        #1;
        check("s3_we", m_we, 1'b1);
        check("s3_wsel", m_wsel, 4'b0011);
        check("s3_wdata", m_wdata, 32'hDEADBEEF);
        check("s3_r0_noack", r0_ack, 1'b0);
        tick();

        // LSU stalls with fetch pending: single timeout pulse, then fetch gets the port.
        m_ack = 0;
        err0_seen = 0; err1_seen = 0;
        for (int i = 0; i < 10; i++) tick();
        check("s5_r1_err_pulses", err1_seen, 1);
        check("s5_r0_err_pulses", err0_seen, 0);

        // Fetch flush with no ack, then a late ack that must not reach fetch.
        r0_syn = 0; r1_syn = 0; tick();
        m_ack = 1; tick();
        m_ack = 0;

        // Reset mid four-beat burst after beat two.
        r0_syn = 1; tick();
        m_ack = 1; tick(); tick();
        a_rst = 1; m_ack = 0; tick();
        a_rst = 0; r0_syn = 1; r1_syn = 1; tick();
        r0_syn = 0; r1_syn = 0; tick();

        for (int i = 0; i < 3000; i++) begin
            bit quiet;
            quiet = (((i / 48) % 4) == 3);
            a_rst  = ($urandom_range(0, 199) == 0);
            r0_syn = r0_syn ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 30);
            r1_syn = r1_syn ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 30);
            r0_addr  = $urandom;
            r1_addr  = $urandom;
            r1_we    = $urandom_range(0, 1);
            r1_wdata = $urandom;
            r1_wsel  = 4'($urandom_range(0, 15));
            m_ack    = quiet ? 1'b0 : ($urandom_range(0, 1) == 1);
            m_last   = ($urandom_range(0, 99) < 35);
            m_rdata  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
